// File: rtl/fp_alu_seq.sv
// fp_alu_seq: single-clock sequential FP add/sub/mul/div with a start/busy/done
// handshake, flush-to-zero operands, truncating rounding and exception flags.
module fp_alu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 cpu_clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           selector,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] out,
   output logic [3:0]           flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 2;          // significand work width, hidden bit at MAN_W
   localparam int EW2  = EXP_W + 2;          // two's-complement exponent work width
   localparam int PW   = 2 * MAN_W + 2;      // full product width
   localparam int CW   = $clog2(MAN_W + 2);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
   localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [2:0] OP_ADD = 3'd0, OP_MUL = 3'd1, OP_DIV = 3'd2, OP_SUB = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_MUL, S_DIV, S_NORM, S_PACK
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, done_q, done_d;
   logic [W-1:0]     out_q, a_q, b_q, spec_res_q;
   logic [3:0]       flags_q, spec_flg_q;
   logic             sgn_q, sub_q, zero_q;
   logic [EW2-1:0]   exp_q;
   logic [SW-1:0]    sig_q, y_q, rem_q;
   logic [CW-1:0]    cnt_q;
   logic             ld_spec, ld_pack, accept;

   // input-side classification
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [W-1:0]     b_in, sp_res;
   logic [3:0]       sp_flg;
   logic             sp_hit, a_zero, b_zero, sxor;

   assign accept = start && !busy_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign out    = out_q;
   assign flags  = flags_q;

   // Decide at accept time whether the operands take the single-state special path
   always_comb begin
      a_exp  = a[MAN_W +: EXP_W];
      b_exp  = b[MAN_W +: EXP_W];
      b_in   = (selector == OP_SUB) ? {~b[W-1], b[W-2:0]} : b;
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      sxor   = a[W-1] ^ b[W-1];
      sp_hit = 1'b0;
      sp_res = '0;
      sp_flg = '0;
      if (selector > OP_SUB || (&a_exp) || (&b_exp)) begin
         sp_hit = 1'b1; sp_res = QNAN; sp_flg = 4'b1000;
      end else begin
         case (selector)
            OP_DIV: begin
               if (a_zero && b_zero) begin
                  sp_hit = 1'b1; sp_res = QNAN; sp_flg = 4'b1000;
               end else if (b_zero) begin
                  sp_hit = 1'b1; sp_res = {sxor, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; sp_flg = 4'b0100;
               end else if (a_zero) begin
                  sp_hit = 1'b1; sp_res = {sxor, {(W-1){1'b0}}};
               end
            end
            OP_MUL: begin
               if (a_zero || b_zero) begin
                  sp_hit = 1'b1; sp_res = {sxor, {(W-1){1'b0}}};
               end
            end
            OP_ADD, OP_SUB: begin
               if (a_zero && b_zero) begin
                  sp_hit = 1'b1; sp_res = '0;
               end else if (a_zero) begin
                  sp_hit = 1'b1; sp_res = b_in;
               end else if (b_zero) begin
                  sp_hit = 1'b1; sp_res = a;
               end
            end
            default: ;
         endcase
      end
   end

   // ALIGN: order by magnitude and shift the smaller significand into place
   logic             swap;
   logic [W-1:0]     big, sml;
   logic [EXP_W-1:0] dif;
   logic [SW-1:0]    sig_big, sig_sml, sml_sh;
   always_comb begin
      swap    = b_q[W-2:0] > a_q[W-2:0];
      big     = swap ? b_q : a_q;
      sml     = swap ? a_q : b_q;
      dif     = big[MAN_W +: EXP_W] - sml[MAN_W +: EXP_W];
      sig_big = SW'({1'b1, big[MAN_W-1:0]});
      sig_sml = SW'({1'b1, sml[MAN_W-1:0]});
      sml_sh  = (32'(dif) > 32'(MAN_W + 1)) ? '0 : (sig_sml >> dif);
   end

   // ADD / MUL / DIV step datapath
   logic [SW-1:0] sum, rem_sub;
   logic [PW-1:0] prod;
   logic          ge;
   always_comb begin
      sum     = sub_q ? (sig_q - y_q) : (sig_q + y_q);
      prod    = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
      ge      = rem_q >= y_q;
      rem_sub = ge ? (rem_q - y_q) : rem_q;
   end

   // NORM: leading-one detect and single shift to put the hidden bit at MAN_W
   logic [EW2-1:0] nsh, nrm_exp;
   logic [SW-1:0]  nrm_sig;
   logic           lz_hit;
   always_comb begin
      nsh    = '0;
      lz_hit = 1'b0;
      for (int i = MAN_W; i >= 0; i--) begin
         if (!lz_hit && sig_q[i]) begin
            lz_hit = 1'b1;
            nsh    = EW2'(MAN_W - i);
         end
      end
      if (sig_q[SW-1]) begin
         nrm_sig = sig_q >> 1;
         nrm_exp = exp_q + EW2'(1);
      end else begin
         nrm_sig = sig_q << nsh;
         nrm_exp = exp_q - nsh;
      end
   end

   // PACK: range-check the signed exponent and assemble the result word
   logic [W-1:0] pk_res;
   logic [3:0]   pk_flg;
   always_comb begin
      pk_res = {sgn_q, exp_q[EXP_W-1:0], sig_q[MAN_W-1:0]};
      pk_flg = '0;
      if (zero_q) begin
         pk_res = '0;
      end else if (!exp_q[EW2-1] && exp_q >= EXP_MAX) begin
         pk_res = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         pk_flg = 4'b0010;
      end else if (exp_q[EW2-1] || exp_q == '0) begin
         pk_res = {sgn_q, {(W-1){1'b0}}};
         pk_flg = 4'b0001;
      end
   end

   // FSM state register
   always_ff @(posedge cpu_clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (sp_hit)                  state_d = S_SPECIAL;
               else if (selector == OP_MUL) state_d = S_MUL;
               else if (selector == OP_DIV) state_d = S_DIV;
               else                         state_d = S_ALIGN;
            end
         end
         S_SPECIAL: state_d = S_IDLE;
         S_ALIGN:   state_d = S_ADD;
         S_ADD:     state_d = S_NORM;
         S_MUL:     state_d = S_NORM;
         S_DIV:     if (cnt_q == CW'(MAN_W + 1)) state_d = S_NORM;
         S_NORM:    state_d = S_PACK;
         S_PACK:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM outputs: result-load strobes and the done pulse
   always_comb begin
      ld_spec = (state_q == S_SPECIAL);
      ld_pack = (state_q == S_PACK);
      done_d  = ld_spec || ld_pack;
   end

   // Datapath and handshake registers
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         busy_q <= 1'b0;  done_q <= 1'b0;
         out_q  <= '0;    flags_q <= '0;
         a_q    <= '0;    b_q <= '0;
         spec_res_q <= '0; spec_flg_q <= '0;
         sgn_q  <= 1'b0;  sub_q <= 1'b0;  zero_q <= 1'b0;
         exp_q  <= '0;    sig_q <= '0;    y_q <= '0;  rem_q <= '0;
         cnt_q  <= '0;
      end else begin
         done_q <= done_d;
         if (accept)      busy_q <= 1'b1;
         else if (done_q) busy_q <= 1'b0;
         if (ld_spec) begin
            out_q   <= spec_res_q;
            flags_q <= spec_flg_q;
         end
         if (ld_pack) begin
            out_q   <= pk_res;
            flags_q <= pk_flg;
         end
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q        <= a;
                  b_q        <= b_in;
                  spec_res_q <= sp_res;
                  spec_flg_q <= sp_flg;
                  zero_q     <= 1'b0;
                  cnt_q      <= '0;
                  // divider seed; ALIGN and MUL overwrite these for their ops
                  rem_q      <= SW'({1'b1, a[MAN_W-1:0]});
                  y_q        <= SW'({1'b1, b[MAN_W-1:0]});
                  sig_q      <= '0;
                  sgn_q      <= sxor;
                  // quotient point sits one bit above MAN_W, folded into the exponent
                  exp_q      <= EW2'(a_exp) - EW2'(b_exp) + EW2'(BIAS - 1);
               end
            end
            S_ALIGN: begin
               sgn_q <= big[W-1];
               sub_q <= a_q[W-1] ^ b_q[W-1];
               exp_q <= EW2'(big[MAN_W +: EXP_W]);
               sig_q <= sig_big;
               y_q   <= sml_sh;
            end
            S_ADD: begin
               sig_q  <= sum;
               zero_q <= (sum == '0);
            end
            S_MUL: begin
               sgn_q <= a_q[W-1] ^ b_q[W-1];
               exp_q <= EW2'(a_q[MAN_W +: EXP_W]) + EW2'(b_q[MAN_W +: EXP_W]) - EW2'(BIAS);
               sig_q <= SW'(prod >> MAN_W);
            end
            S_DIV: begin
               sig_q <= {sig_q[SW-2:0], ge};
               rem_q <= SW'({rem_sub, 1'b0});
               cnt_q <= (cnt_q == CW'(MAN_W + 1)) ? '0 : cnt_q + CW'(1);
            end
            S_NORM: begin
               if (!zero_q) begin
                  sig_q <= nrm_sig;
                  exp_q <= nrm_exp;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed vectors with hand-computed results for fp_alu_seq.
module tb_fp_alu_seq;
   logic        cpu_clk = 1'b0;
   logic        reset, start;
   logic [2:0]  selector;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] out;
   logic [3:0]  flags;
   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   fp_alu_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .cpu_clk(cpu_clk), .reset(reset), .start(start), .selector(selector),
      .a(a), .b(b), .busy(busy), .done(done), .out(out), .flags(flags)
   );

   always #5 cpu_clk = ~cpu_clk;

   // count done pulses, sampled mid-cycle
   always @(negedge cpu_clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // present a request for one edge, then scramble the inputs
   task automatic issue(input logic [2:0] sel, input logic [31:0] av, input logic [31:0] bv);
      @(negedge cpu_clk);
      start = 1'b1; selector = sel; a = av; b = bv;
      @(posedge cpu_clk); #1;
      start = 1'b0; selector = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   // edges counted after the current one until done is seen; -1 on timeout
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge cpu_clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [2:0] sel, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] eo, input logic [3:0] ef,
                      input int el);
      int lat;
      issue(sel, av, bv);
      wait_done(lat);
      chk({tag, ":lat"}, 64'(lat), 64'(el));
      chk({tag, ":out"}, 64'(out), 64'(eo));
      chk({tag, ":flg"}, 64'(flags), 64'(ef));
      chk({tag, ":busy"}, 64'(busy), 64'd1);
      @(posedge cpu_clk); #1;
      chk({tag, ":end"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      int lat, n0;
      reset = 1'b1; start = 1'b0; selector = '0; a = '0; b = '0;
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      reset = 1'b0;

      run("mul5x2",   3'd1, 32'h40A00000, 32'h40000000, 32'h41200000, 4'b0000, 3);
      run("mulneg",   3'd1, 32'hC0A00000, 32'hC0000000, 32'h41200000, 4'b0000, 3);
      run("div13",    3'd2, 32'h415C0000, 32'hC0B00000, 32'hC0200000, 4'b0000, 27);
      run("div8",     3'd2, 32'h41000000, 32'h40000000, 32'h40800000, 4'b0000, 27);
      run("add3",     3'd0, 32'h40200000, 32'h3F000000, 32'h40400000, 4'b0000, 4);
      run("addbig",   3'd0, 32'h4AC65D40, 32'h41600000, 32'h4AC65D5C, 4'b0000, 4);
      run("subcan",   3'd3, 32'h40200000, 32'h40200000, 32'h00000000, 4'b0000, 4);
      run("subneg",   3'd3, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 4);
      run("divz",     3'd2, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
      run("zz",       3'd2, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
      run("ovf",      3'd1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 3);
      run("unf",      3'd1, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 3);
      run("badsel",   3'd5, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
      run("mulinf",   3'd1, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
      run("add0",     3'd0, 32'h00000000, 32'h40400000, 32'h40400000, 4'b0000, 1);
      run("sub0",     3'd3, 32'h00000000, 32'h3F800000, 32'hBF800000, 4'b0000, 1);

      // start held high for the whole divide produces a single done
      n0 = done_cnt;
      @(negedge cpu_clk);
      start = 1'b1; selector = 3'd2; a = 32'h41000000; b = 32'h40000000;
      @(posedge cpu_clk); #1;
      wait_done(lat);
      chk("held:lat", 64'(lat), 64'd27);
      start = 1'b0;
      repeat (5) @(posedge cpu_clk);
      #1;
      chk("held:ndone", 64'(done_cnt - n0), 64'd1);
      chk("held:out", 64'(out), 64'h40800000);

      // a request while busy is dropped
      issue(3'd1, 32'h40A00000, 32'h40000000);
      @(negedge cpu_clk);
      start = 1'b1; selector = 3'd2; a = 32'h41000000; b = 32'h40000000;
      @(posedge cpu_clk); #1;
      start = 1'b0;
      wait_done(lat);
      chk("ign:lat", 64'(lat), 64'd2);
      chk("ign:out", 64'(out), 64'h41200000);
      @(posedge cpu_clk); #1;
      n0 = done_cnt;
      repeat (35) @(posedge cpu_clk);
      #1;
      chk("ign:nodone", 64'(done_cnt - n0), 64'd0);
      chk("ign:hold", 64'(out), 64'h41200000);

      // start raised in the done cycle is ignored, then taken the cycle after
      issue(3'd0, 32'h40200000, 32'h3F000000);
      wait_done(lat);
      chk("b2b:lat0", 64'(lat), 64'd4);
      @(negedge cpu_clk);
      start = 1'b1; selector = 3'd1; a = 32'hC0A00000; b = 32'hC0000000;
      @(posedge cpu_clk); #1;
      chk("b2b:idle", 64'({busy, done}), 64'd0);
      @(posedge cpu_clk); #1;
      start = 1'b0;
      chk("b2b:busy", 64'(busy), 64'd1);
      wait_done(lat);
      chk("b2b:lat1", 64'(lat), 64'd3);
      chk("b2b:out", 64'(out), 64'h41200000);
      @(posedge cpu_clk); #1;

      // reset in the middle of a divide aborts it
      issue(3'd2, 32'h415C0000, 32'hC0B00000);
      repeat (10) @(posedge cpu_clk);
      #1;
      reset = 1'b1;
      @(posedge cpu_clk); #1;
      reset = 1'b0;
      chk("abort:state", 64'({busy, done, flags}), 64'd0);
      chk("abort:out", 64'(out), 64'd0);
      n0 = done_cnt;
      repeat (40) @(posedge cpu_clk);
      #1;
      chk("abort:nodone", 64'(done_cnt - n0), 64'd0);
      run("postrst", 3'd1, 32'h40A00000, 32'h40000000, 32'h41200000, 4'b0000, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
